// File: rtl/vga_scanout_if.sv
// Frame-buffer read port between the VGA scanout (master) and the buffer (slave).
// The scanout presents a registered pixel address with a select. The buffer answers
// with 12-bit RGB444 data {R[11:8],G[7:4],B[3:0]} within the same pixel slot.
interface vga_scanout_if;
    logic [11:0] buf_x;
    logic [11:0] buf_y;
    logic        buf_select;
    logic        buf_wen;
    logic [11:0] buf_rdata;

    modport master (
        output buf_x,
        output buf_y,
        output buf_select,
        output buf_wen,
        input  buf_rdata
    );

    modport slave (
        input  buf_x,
        input  buf_y,
        input  buf_select,
        input  buf_wen,
        output buf_rdata
    );
endinterface

// File: rtl/vga_scanout.sv
// VGA scanout: 640x480@60 timing from a 4x pixel clock (aclk4).
// Each screen slot fetches the buffer pixel for the following slot with a 2x
// nearest-neighbour upscale. RGB444 and active-low HS/VS are registered together.
// Optional feature: define VGA_SCANOUT_TESTPAT_EN to add the test_mode input.
// When test_mode is 1, the design shows 8 colour bars and stops using the buffer.
module vga_scanout #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FRONT        = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BACK         = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FRONT        = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BACK         = 33,
    parameter int CLKS_PER_PIXEL = 4,
    parameter int SCALE_SHIFT    = 1
) (
    input  logic               aclk4,
    input  logic               aresetn,
    vga_scanout_if.master      bus,
`ifdef VGA_SCANOUT_TESTPAT_EN
    input  logic               test_mode,
`endif
    output logic [3:0]         vga_r,
    output logic [3:0]         vga_g,
    output logic [3:0]         vga_b,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               frame_start
);

    localparam int              PH_W    = (CLKS_PER_PIXEL > 1) ? $clog2(CLKS_PER_PIXEL) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLKS_PER_PIXEL - 1);
    localparam logic [11:0]     H_ACT   = 12'(H_ACTIVE);
    localparam logic [11:0]     V_ACT   = 12'(V_ACTIVE);
    localparam logic [11:0]     H_LAST  = 12'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [11:0]     V_LAST  = 12'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [11:0]     HS_BEG  = 12'(H_ACTIVE + H_FRONT);
    localparam logic [11:0]     HS_END  = 12'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [11:0]     VS_BEG  = 12'(V_ACTIVE + V_FRONT);
    localparam logic [11:0]     VS_END  = 12'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [PH_W-1:0] phase;
    logic [11:0]     hcount;
    logic [11:0]     vcount;
    logic            slot_adv;
    logic [11:0]     nh, nv;    // slot entered at the next slot advance
    logic [11:0]     nnh, nnv;  // slot after that: prefetch target once (nh,nv) is live
    logic [11:0]     pix_rgb;
    logic            fetch_en;

    function automatic logic [11:0] step_h(input logic [11:0] h);
        return (h == H_LAST) ? 12'd0 : h + 12'd1;
    endfunction

    function automatic logic [11:0] step_v(input logic [11:0] h, input logic [11:0] v);
        if (h != H_LAST) return v;
        return (v == V_LAST) ? 12'd0 : v + 12'd1;
    endfunction

    function automatic logic is_active(input logic [11:0] h, input logic [11:0] v);
        return (h < H_ACT) && (v < V_ACT);
    endfunction

`ifdef VGA_SCANOUT_TESTPAT_EN
    localparam int BAR_W = H_ACTIVE / 8;

    // Bar index from threshold compares avoids a divider; bits of k pick R/G/B.
    function automatic logic [11:0] bar_rgb(input logic [11:0] h);
        logic [2:0] k;
        k = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (h >= 12'(i * BAR_W)) k = 3'(i);
        end
        return {{4{k[2]}}, {4{k[1]}}, {4{k[0]}}};
    endfunction
`endif

    assign slot_adv    = (phase == PH_LAST);
    assign bus.buf_wen = 1'b0;

    // Look one and two slots ahead of the live counters.
    always_comb begin
        nh  = step_h(hcount);
        nv  = step_v(hcount, vcount);
        nnh = step_h(nh);
        nnv = step_v(nh, nv);
    end

    // Pick the pixel source and decide whether the upcoming prefetch needs the buffer.
    always_comb begin
        pix_rgb  = bus.buf_rdata;
        fetch_en = is_active(nnh, nnv);
`ifdef VGA_SCANOUT_TESTPAT_EN
        if (test_mode) begin
            pix_rgb  = bar_rgb(nh);
            fetch_en = 1'b0;
        end
`endif
    end

    // Sub-pixel phase counter; the last phase marks the slot-advance edge.
    always_ff @(posedge aclk4 or negedge aresetn) begin
        if (!aresetn)           phase <= '0;
        else if (slot_adv)      phase <= '0;
        else                    phase <= phase + 1'b1;
    end

    // Screen position counters, stepped once per slot.
    always_ff @(posedge aclk4 or negedge aresetn) begin
        if (!aresetn) begin
            hcount <= 12'd0;
            vcount <= 12'd0;
        end else if (slot_adv) begin
            hcount <= nh;
            vcount <= nv;
        end
    end

    // Colour and sync registers load together, so the DAC sees them aligned.
    always_ff @(posedge aclk4 or negedge aresetn) begin
        if (!aresetn) begin
            {vga_r, vga_g, vga_b} <= 12'd0;
            vga_hs                <= 1'b1;
            vga_vs                <= 1'b1;
            frame_start           <= 1'b0;
        end else begin
            frame_start <= slot_adv && (nh == 12'd0) && (nv == 12'd0);
            if (slot_adv) begin
                {vga_r, vga_g, vga_b} <= is_active(nh, nv) ? pix_rgb : 12'd0;
                vga_hs                <= !((nh >= HS_BEG) && (nh < HS_END));
                vga_vs                <= !((nv >= VS_BEG) && (nv < VS_END));
            end
        end
    end

    // Prefetch address for the slot after the one being entered.
    // During blanking, the address holds its last value.
    always_ff @(posedge aclk4 or negedge aresetn) begin
        if (!aresetn) begin
            bus.buf_x      <= 12'd0;
            bus.buf_y      <= 12'd0;
            bus.buf_select <= 1'b0;
        end else if (slot_adv) begin
            bus.buf_select <= fetch_en;
            if (is_active(nnh, nnv)) begin
                bus.buf_x <= nnh >> SCALE_SHIFT;
                bus.buf_y <= nnv >> SCALE_SHIFT;
            end
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout on a shrunken raster so whole frames fit in a short run.
// Horizontal: 16 active + 2 front + 3 sync + 3 back = 24 slots/line; HS low for h = 18..20.
// Vertical:   6 active + 1 front + 2 sync + 1 back = 10 lines/frame; VS low for v = 7..8.
// One frame is 24*10*4 = 960 aclk4 cycles. The buffer model returns {x[3:0], y[3:0], 4'h5},
// or a constant 12'hFFF when ff_mode is set.
module tb_vga_scanout;
    localparam int HT  = 24;
    localparam int VT  = 10;
    localparam int CPP = 4;

    logic        aclk4   = 1'b0;
    logic        aresetn = 1'b1;
    logic        ff_mode = 1'b0;
    logic [3:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, frame_start;
    int          total = 0;
    int          bad   = 0;
    int          now   = 0;
`ifdef VGA_SCANOUT_TESTPAT_EN
    logic        test_mode = 1'b0;
`endif

    vga_scanout_if bus ();

    assign bus.buf_rdata = ff_mode ? 12'hFFF : {bus.buf_x[3:0], bus.buf_y[3:0], 4'h5};

    vga_scanout #(
        .H_ACTIVE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLKS_PER_PIXEL(CPP), .SCALE_SHIFT(1)
    ) dut (
        .aclk4       (aclk4),
        .aresetn     (aresetn),
        .bus         (bus.master),
`ifdef VGA_SCANOUT_TESTPAT_EN
        .test_mode   (test_mode),
`endif
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .frame_start (frame_start)
    );

    always #5 aclk4 = ~aclk4;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Advance to cycle 'off' of slot (h,v) in frame f, counted from the last reset release.
    // Sampling happens on the falling edge.
    task automatic at_slot(input int f, input int h, input int v, input int off);
        int target;
        target = CPP * ((f * VT + v) * HT + h) + off;
        while (now < target) begin
            @(posedge aclk4);
            now++;
            @(negedge aclk4);
        end
    endtask

    initial begin
        // Reset held from power-up
        #3 aresetn = 1'b0;
        repeat (3) @(negedge aclk4);
        check("rst_rgb",  {vga_r, vga_g, vga_b}, 12'h000);
        check("rst_hs",   12'(vga_hs), 12'd1);
        check("rst_vs",   12'(vga_vs), 12'd1);
        check("rst_bx",   bus.buf_x, 12'd0);
        check("rst_by",   bus.buf_y, 12'd0);
        check("rst_sel",  12'(bus.buf_select), 12'd0);
        check("rst_fs",   12'(frame_start), 12'd0);
        check("rst_wen",  12'(bus.buf_wen), 12'd0);
        aresetn = 1'b1;
        now = 0;

        // Slot (0,0) right after release: still reset values
        at_slot(0, 0, 0, 0);
        check("s00_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("s00_fs",  12'(frame_start), 12'd0);
        check("s00_bx",  bus.buf_x, 12'd0);
        at_slot(0, 1, 0, 0);
        check("s10_rgb", {vga_r, vga_g, vga_b}, 12'h005);
        check("s10_bx",  bus.buf_x, 12'd1);
        check("s10_sel", 12'(bus.buf_select), 12'd1);
        at_slot(0, 2, 0, 2);
        check("s20_rgb", {vga_r, vga_g, vga_b}, 12'h105);
        check("s20_bx",  bus.buf_x, 12'd1);
        at_slot(0, 3, 0, 0);
        check("s30_rgb", {vga_r, vga_g, vga_b}, 12'h105);
        check("s30_bx",  bus.buf_x, 12'd2);
        at_slot(0, 15, 0, 0);
        check("s150_rgb", {vga_r, vga_g, vga_b}, 12'h705);
        check("s150_bx",  bus.buf_x, 12'd7);
        check("s150_sel", 12'(bus.buf_select), 12'd0);
        at_slot(0, 16, 0, 0);
        check("s160_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        at_slot(0, 17, 0, 3);
        check("hs_17", 12'(vga_hs), 12'd1);
        at_slot(0, 18, 0, 0);
        check("hs_18", 12'(vga_hs), 12'd0);
        at_slot(0, 20, 0, 3);
        check("hs_20", 12'(vga_hs), 12'd0);
        at_slot(0, 21, 0, 0);
        check("hs_21", 12'(vga_hs), 12'd1);
        at_slot(0, 23, 0, 0);
        check("s230_bx",  bus.buf_x, 12'd0);
        check("s230_by",  bus.buf_y, 12'd0);
        check("s230_sel", 12'(bus.buf_select), 12'd1);
        at_slot(0, 0, 1, 0);
        check("s01_rgb", {vga_r, vga_g, vga_b}, 12'h005);
        at_slot(0, 0, 2, 0);
        check("s02_rgb", {vga_r, vga_g, vga_b}, 12'h015);
        at_slot(0, 2, 2, 0);
        check("s22_rgb", {vga_r, vga_g, vga_b}, 12'h115);
        at_slot(0, 15, 5, 0);
        check("last_rgb", {vga_r, vga_g, vga_b}, 12'h725);
        at_slot(0, 0, 6, 0);
        check("s06_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("s06_sel", 12'(bus.buf_select), 12'd0);
        check("s06_bx",  bus.buf_x, 12'd7);
        check("s06_by",  bus.buf_y, 12'd2);
        check("vs_6",    12'(vga_vs), 12'd1);
        at_slot(0, 0, 7, 0);
        check("vs_7", 12'(vga_vs), 12'd0);
        at_slot(0, 23, 8, 3);
        check("vs_8", 12'(vga_vs), 12'd0);
        at_slot(0, 0, 9, 0);
        check("vs_9", 12'(vga_vs), 12'd1);
        at_slot(0, 23, 9, 0);
        check("wrap_bx",  bus.buf_x, 12'd0);
        check("wrap_by",  bus.buf_y, 12'd0);
        check("wrap_sel", 12'(bus.buf_select), 12'd1);
        check("wrap_fs",  12'(frame_start), 12'd0);

        // Second frame: frame_start pulse, then blanking with an all-ones buffer
        at_slot(1, 0, 0, 0);
        check("f1_fs",  12'(frame_start), 12'd1);
        check("f1_rgb", {vga_r, vga_g, vga_b}, 12'h005);
        at_slot(1, 0, 0, 1);
        check("f1_fs_end", 12'(frame_start), 12'd0);
        ff_mode = 1'b1;
        at_slot(1, 5, 1, 0);
        check("ff_act_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
        at_slot(1, 14, 1, 0);
        check("ff_sel14", 12'(bus.buf_select), 12'd1);
        at_slot(1, 15, 1, 0);
        check("ff_sel15", 12'(bus.buf_select), 12'd0);
        at_slot(1, 16, 1, 0);
        check("ff_hblank_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        at_slot(1, 5, 7, 0);
        check("ff_vblank_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("ff_vblank_sel", 12'(bus.buf_select), 12'd0);

        // Asynchronous reset mid-frame
        at_slot(1, 10, 8, 1);
        aresetn = 1'b0;
        #1;
        check("ar_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("ar_vs",  12'(vga_vs), 12'd1);
        check("ar_bx",  bus.buf_x, 12'd0);
        check("ar_by",  bus.buf_y, 12'd0);
        repeat (2) @(negedge aclk4);
        aresetn = 1'b1;
        now = 0;
        at_slot(0, 0, 0, 3);
        check("ar_s00_rgb", {vga_r, vga_g, vga_b}, 12'h000);
        check("ar_s00_sel", 12'(bus.buf_select), 12'd0);
        check("ar_s00_fs",  12'(frame_start), 12'd0);
        at_slot(0, 1, 0, 0);
        check("ar_s10_rgb", {vga_r, vga_g, vga_b}, 12'hFFF);
        check("ar_s10_bx",  bus.buf_x, 12'd1);

`ifdef VGA_SCANOUT_TESTPAT_EN
        // Colour bars are 2 slots wide on this raster
        test_mode = 1'b1;
        at_slot(0, 0, 1, 0);
        check("tp_bar0", {vga_r, vga_g, vga_b}, 12'h000);
        at_slot(0, 2, 1, 0);
        check("tp_bar1", {vga_r, vga_g, vga_b}, 12'h00F);
        check("tp_sel",  12'(bus.buf_select), 12'd0);
        at_slot(0, 14, 1, 0);
        check("tp_bar7", {vga_r, vga_g, vga_b}, 12'hFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
